// File: rtl/aap_debug_pkg.sv
// Shared constants for the UART debug controller: command/response bytes,
// FSM state encoding and the default GET_COUNT timeout.
package aap_debug_pkg;

  localparam logic [7:0] CMD_STOP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'
  localparam logic [7:0] CMD_PC    = 8'h50;  // 'P'
  localparam logic [7:0] CMD_STEP  = 8'h4E;  // 'N'

  localparam logic [7:0] RESP_ACK  = 8'h2B;  // '+'
  localparam logic [7:0] RESP_NAK  = 8'h3F;  // '?'

  localparam int DEFAULT_TIMEOUT = 1023;
  localparam int CNT_W           = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GET_COUNT = 2'd1,
    ST_RESP      = 2'd2
  } state_e;

endpackage

// File: rtl/uart_debug_ctrl_if.sv
// Signal bundle between the UART/core side and the debug controller.
interface uart_debug_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic [5:0] programcounter;
  logic       nop_stop;
  logic       uart_stop;
  logic       uart_continue;
  logic       uart_reset;
  logic       uart_step_enable;
  logic [5:0] uart_step_volume;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       halted;
  logic       rx_overrun;

  modport master (
    input  rx_data, rx_valid, tx_ready, programcounter, nop_stop,
    output uart_stop, uart_continue, uart_reset, uart_step_enable,
           uart_step_volume, tx_data, tx_valid, halted, rx_overrun
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, programcounter, nop_stop,
    input  uart_stop, uart_continue, uart_reset, uart_step_enable,
           uart_step_volume, tx_data, tx_valid, halted, rx_overrun
  );
endinterface

// File: rtl/uart_debug_ctrl.sv
// UART debug command decoder: one-byte commands become one-cycle fetch-control
// pulses, each answered by a single response byte held until accepted.
module uart_debug_ctrl
  import aap_debug_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic             clock,
  input logic             reset,
  uart_debug_ctrl_if.master dbg
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_q, stop_d, cont_q, cont_d, rst_q, rst_d, step_q, step_d;
  logic [5:0]       vol_q, vol_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             halted_q, halted_d;
  logic             ovr_q, ovr_d;
  logic             go_resp;
  logic [7:0]       resp;

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    stop_d     = 1'b0;
    cont_d     = 1'b0;
    rst_d      = 1'b0;
    step_d     = 1'b0;
    vol_d      = '0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    halted_d   = halted_q;
    ovr_d      = ovr_q;
    go_resp    = 1'b0;
    resp       = RESP_NAK;

    case (state_q)
      ST_IDLE: begin
        if (dbg.rx_valid) begin
          go_resp = 1'b1;
          resp    = RESP_ACK;
          case (dbg.rx_data)
            CMD_STOP:  begin stop_d = 1'b1; halted_d = 1'b1; end
            CMD_CONT:  begin cont_d = 1'b1; halted_d = 1'b0; end
            CMD_RESET: begin rst_d  = 1'b1; halted_d = 1'b1; end
            CMD_PC:    resp = {2'b00, dbg.programcounter};
            CMD_STEP:  begin go_resp = 1'b0; state_d = ST_GET_COUNT; end
            default:   resp = RESP_NAK;
          endcase
        end
      end
      ST_GET_COUNT: begin
        if (dbg.rx_valid) begin
          go_resp = 1'b1;
          if (dbg.rx_data[7:6] == 2'b00 && dbg.rx_data[5:0] != 6'd0) begin
            step_d = 1'b1;
            vol_d  = dbg.rx_data[5:0];
            resp   = RESP_ACK;
          end
        end else if (cnt_q == TO_LAST) begin
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        // Bytes arriving while a response is pending are never decoded,
        // including on the cycle the response is accepted.
        if (dbg.rx_valid) ovr_d = 1'b1;
        if (dbg.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_resp) begin
      state_d    = ST_RESP;
      tx_valid_d = 1'b1;
      tx_data_d  = resp;
    end

    // A core self-halt overrides a concurrent continue.
    if (dbg.nop_stop) halted_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      cont_q     <= 1'b0;
      rst_q      <= 1'b0;
      step_q     <= 1'b0;
      vol_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      halted_q   <= 1'b1;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stop_q     <= stop_d;
      cont_q     <= cont_d;
      rst_q      <= rst_d;
      step_q     <= step_d;
      vol_q      <= vol_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      halted_q   <= halted_d;
      ovr_q      <= ovr_d;
    end
  end

  assign dbg.uart_stop        = stop_q;
  assign dbg.uart_continue    = cont_q;
  assign dbg.uart_reset       = rst_q;
  assign dbg.uart_step_enable = step_q;
  assign dbg.uart_step_volume = vol_q;
  assign dbg.tx_data          = tx_data_q;
  assign dbg.tx_valid         = tx_valid_q;
  assign dbg.halted           = halted_q;
  assign dbg.rx_overrun       = ovr_q;

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Self-checking bench for uart_debug_ctrl: directed vector table, hand-written
// corner sequences and randomized commands against a behavioural model.
module tb_uart_debug_ctrl;
  import aap_debug_pkg::*;

  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_debug_ctrl_if dbg();
  uart_debug_ctrl #(.TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .dbg(dbg));

  int n_chk  = 0;
  int n_fail = 0;
  bit m_halted;

  typedef struct {
    logic       two;
    logic [7:0] b0, b1;
    logic [5:0] pc;
    int         hold;
    logic [7:0] e_resp;
    logic [3:0] e_pulse;   // {stop, continue, reset, step}
    logic [5:0] e_vol;
    logic       e_halt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {dbg.uart_stop, dbg.uart_continue, dbg.uart_reset, dbg.uart_step_enable};
  endfunction

  function automatic vec_t mk(input logic two, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [5:0] pc, input int hold, input logic [7:0] r,
                              input logic [3:0] p, input logic [5:0] vol, input logic h);
    vec_t v;
    v.two = two; v.b0 = b0; v.b1 = b1; v.pc = pc; v.hold = hold;
    v.e_resp = r; v.e_pulse = p; v.e_vol = vol; v.e_halt = h;
    return v;
  endfunction

  // Reference model: expected outcome of one command exchange from the
  // command table, tracking the halt view across commands.
  function automatic vec_t model(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [5:0] pc, input int hold);
    vec_t v;
    v = mk(b0 == CMD_STEP, b0, b1, pc, hold, RESP_ACK, 4'b0000, 6'd0, 1'b0);
    if (b0 == CMD_STOP) begin v.e_pulse = 4'b1000; m_halted = 1'b1; end
    else if (b0 == CMD_CONT) begin v.e_pulse = 4'b0100; m_halted = 1'b0; end
    else if (b0 == CMD_RESET) begin v.e_pulse = 4'b0010; m_halted = 1'b1; end
    else if (b0 == CMD_PC) v.e_resp = {2'b00, pc};
    else if (b0 == CMD_STEP) begin
      if (b1 >= 8'd1 && b1 <= 8'd63) begin v.e_pulse = 4'b0001; v.e_vol = b1[5:0]; end
      else v.e_resp = RESP_NAK;
    end else v.e_resp = RESP_NAK;
    v.e_halt = m_halted;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    dbg.rx_data  = b;
    dbg.rx_valid = 1'b1;
    @(negedge clock);
    dbg.rx_valid = 1'b0;
    dbg.rx_data  = 8'h00;
  endtask

  task automatic release_resp();
    dbg.tx_ready = 1'b1;
    @(negedge clock);
    dbg.tx_ready = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    dbg.programcounter = v.pc;
    if (v.two) begin
      send_byte(v.b0);
      chk({tag, ".mid_txv"}, dbg.tx_valid, 1'b0);
      chk({tag, ".mid_pulse"}, pulses(), 4'b0000);
      send_byte(v.b1);
    end else begin
      send_byte(v.b0);
    end
    chk({tag, ".txv"}, dbg.tx_valid, 1'b1);
    chk({tag, ".txd"}, dbg.tx_data, v.e_resp);
    chk({tag, ".pulse"}, pulses(), v.e_pulse);
    chk({tag, ".vol"}, dbg.uart_step_volume, v.e_vol);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clock);
      chk({tag, ".hold_pulse"}, pulses(), 4'b0000);
      chk({tag, ".hold_vol"}, dbg.uart_step_volume, 6'd0);
      chk({tag, ".hold_txv"}, dbg.tx_valid, 1'b1);
      chk({tag, ".hold_txd"}, dbg.tx_data, v.e_resp);
    end
    release_resp();
    chk({tag, ".rel_txv"}, dbg.tx_valid, 1'b0);
    chk({tag, ".rel_pulse"}, pulses(), 4'b0000);
    chk({tag, ".halted"}, dbg.halted, v.e_halt);
  endtask

  vec_t tbl[$];
  vec_t rv;
  int   cyc;

  initial begin
    reset = 1'b1;
    dbg.rx_data = 8'h00; dbg.rx_valid = 1'b0; dbg.tx_ready = 1'b0;
    dbg.programcounter = 6'd0; dbg.nop_stop = 1'b0;

    tbl.push_back(mk(0, CMD_STOP,  8'h00, 6'h00, 5, RESP_ACK, 4'b1000, 6'd0,  1));
    tbl.push_back(mk(1, CMD_STEP,  8'h05, 6'h00, 1, RESP_ACK, 4'b0001, 6'd5,  1));
    tbl.push_back(mk(1, CMD_STEP,  8'h00, 6'h00, 2, RESP_NAK, 4'b0000, 6'd0,  1));
    tbl.push_back(mk(0, CMD_PC,    8'h00, 6'h2A, 1, 8'h2A,    4'b0000, 6'd0,  1));
    tbl.push_back(mk(0, CMD_CONT,  8'h00, 6'h00, 0, RESP_ACK, 4'b0100, 6'd0,  0));
    tbl.push_back(mk(0, CMD_RESET, 8'h00, 6'h00, 1, RESP_ACK, 4'b0010, 6'd0,  1));
    tbl.push_back(mk(0, 8'h41,     8'h00, 6'h00, 1, RESP_NAK, 4'b0000, 6'd0,  1));
    tbl.push_back(mk(1, CMD_STEP,  8'hC5, 6'h00, 0, RESP_NAK, 4'b0000, 6'd0,  1));
    tbl.push_back(mk(1, CMD_STEP,  8'h3F, 6'h00, 0, RESP_ACK, 4'b0001, 6'h3F, 1));
    tbl.push_back(mk(0, CMD_CONT,  8'h00, 6'h00, 0, RESP_ACK, 4'b0100, 6'd0,  0));
    tbl.push_back(mk(0, CMD_PC,    8'h00, 6'h15, 0, 8'h15,    4'b0000, 6'd0,  0));
    tbl.push_back(mk(1, CMD_STEP,  8'h01, 6'h00, 1, RESP_ACK, 4'b0001, 6'd1,  0));

    repeat (2) @(negedge clock);
    chk("rst.txv", dbg.tx_valid, 1'b0);
    chk("rst.txd", dbg.tx_data, 8'h00);
    chk("rst.halted", dbg.halted, 1'b1);
    chk("rst.ovr", dbg.rx_overrun, 1'b0);
    chk("rst.pulse", pulses(), 4'b0000);
    chk("rst.vol", dbg.uart_step_volume, 6'd0);
    reset = 1'b0;

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Byte during a pending response is dropped and flagged.
    dbg.programcounter = 6'h2A;
    send_byte(CMD_PC);
    chk("ovr.txd0", dbg.tx_data, 8'h2A);
    send_byte(CMD_CONT);
    chk("ovr.pulse", pulses(), 4'b0000);
    chk("ovr.flag", dbg.rx_overrun, 1'b1);
    chk("ovr.txv", dbg.tx_valid, 1'b1);
    chk("ovr.txd1", dbg.tx_data, 8'h2A);
    release_resp();
    chk("ovr.halted", dbg.halted, 1'b0);

    // Byte arriving on the accepting cycle is also dropped.
    dbg.programcounter = 6'h11;
    send_byte(CMD_PC);
    dbg.tx_ready = 1'b1; dbg.rx_valid = 1'b1; dbg.rx_data = CMD_STOP;
    @(negedge clock);
    dbg.tx_ready = 1'b0; dbg.rx_valid = 1'b0; dbg.rx_data = 8'h00;
    chk("exit.txv0", dbg.tx_valid, 1'b0);
    chk("exit.pulse0", pulses(), 4'b0000);
    @(negedge clock);
    chk("exit.pulse1", pulses(), 4'b0000);
    chk("exit.txv1", dbg.tx_valid, 1'b0);
    chk("exit.halted", dbg.halted, 1'b0);

    // GET_COUNT timeout, twice to confirm the counter restarts.
    for (int k = 0; k < 2; k++) begin
      send_byte(CMD_STEP);
      cyc = 0;
      while (!dbg.tx_valid && cyc < TO + 10) begin
        @(negedge clock);
        cyc++;
      end
      chk($sformatf("tmo%0d.cycles", k), cyc, TO);
      chk($sformatf("tmo%0d.txd", k), dbg.tx_data, RESP_NAK);
      chk($sformatf("tmo%0d.pulse", k), pulses(), 4'b0000);
      release_resp();
      chk($sformatf("tmo%0d.idle", k), dbg.tx_valid, 1'b0);
    end
    run_txn(mk(0, 8'h41, 8'h00, 6'h00, 0, RESP_NAK, 4'b0000, 6'd0, 0), "after_tmo");

    // Self-halt wins over a simultaneous continue, which still pulses.
    @(negedge clock);
    dbg.rx_data = CMD_CONT; dbg.rx_valid = 1'b1; dbg.nop_stop = 1'b1;
    @(negedge clock);
    dbg.rx_valid = 1'b0; dbg.nop_stop = 1'b0;
    chk("nopc.pulse", pulses(), 4'b0100);
    chk("nopc.halted", dbg.halted, 1'b1);
    release_resp();

    run_txn(mk(0, CMD_CONT, 8'h00, 6'h00, 0, RESP_ACK, 4'b0100, 6'd0, 0), "cont");
    @(negedge clock);
    dbg.nop_stop = 1'b1;
    @(negedge clock);
    dbg.nop_stop = 1'b0;
    chk("nop.halted", dbg.halted, 1'b1);
    chk("nop.txv", dbg.tx_valid, 1'b0);

    // Asynchronous reset while a response is pending.
    send_byte(CMD_PC);
    chk("rstresp.pre", dbg.tx_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rstresp.txv", dbg.tx_valid, 1'b0);
    chk("rstresp.txd", dbg.tx_data, 8'h00);
    chk("rstresp.ovr", dbg.rx_overrun, 1'b0);
    chk("rstresp.halted", dbg.halted, 1'b1);
    @(negedge clock);
    reset = 1'b0;

    m_halted = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b0, b1;
      case ($urandom_range(0, 5))
        0: b0 = CMD_STOP;
        1: b0 = CMD_CONT;
        2: b0 = CMD_RESET;
        3: b0 = CMD_PC;
        4: b0 = CMD_STEP;
        default: b0 = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 2) == 0) b1 = 8'($urandom_range(0, 255));
      else b1 = {2'b00, 6'($urandom_range(0, 63))};
      rv = model(b0, b1, 6'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
